fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch stage directly upstream of the branch-prediction table: owns the PC register and drives the BTB's fetch-side inputs (pc_F, pc_present, inst_F).
- Consumes the BTB's predicted next PC plus its X-stage corrections (pc_sel / hit_miss), selects the next PC, and reads instruction memory.
- Registers the fetched instruction into the IF/ID pipeline register, with stall, flush and bubble insertion.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- PC_IDX_W, 13, width of the BTB index output pc_present_o.
- NOP_INST, 32'h0000_0013, instruction injected into IF/ID on a flush or bubble (addi x0,x0,0).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- stall_i  in  1  hazard-unit stall; holds the PC and IF/ID.
- imem_addr_o  out  32  instruction memory address (= current PC).
- imem_rdata_i  in  32  instruction word; combinational read, valid in the same cycle.
- pc_F_o  out  32  current PC + 4, the sequential next PC driven to the BTB.
- pc_present_o  out  PC_IDX_W  PC[PC_IDX_W+1:2], the BTB lookup index.
- inst_F_o  out  32  imem_rdata_i passed through to the BTB.
- pred_pc_i  in  32  BTB predicted next PC (returns pc_F_o when not predicted taken).
- pc_sel_i  in  1  BTB redirect: branch/jump taken but not predicted.
- redirect_pc_i  in  32  redirect target (BTB pc_result).
- hit_miss_i  in  1  BTB mispredict: predicted taken, actually not taken.
- pc_X_i  in  32  PC of the X-stage instruction; used to recover on hit_miss_i.
- pc_D_o  out  32  IF/ID PC.
- inst_D_o  out  32  IF/ID instruction.
- pred_taken_D_o  out  1  IF/ID flag: this instruction was fetched with a taken prediction.
- valid_D_o  out  1  IF/ID valid.
- flush_o  out  1  combinational; kills ID/EX this cycle.
- misalign_o  out  1  one-cycle pulse; the redirect target had bit 1 set.
- perf_redirect_o  out  32  redirect/mispredict counter; tied to 0 unless the optional feature is compiled in.
- perf_pred_taken_o  out  32  taken-prediction counter; tied to 0 unless the optional feature is compiled in.

Behaviour:
- Reset, synchronous and active-high:
  - pc <= RESET_PC.
  - valid_D_o=0, inst_D_o=NOP_INST, pc_D_o=0, pred_taken_D_o=0, misalign_o=0.
  - Perf counters cleared.
  - The first fetch is at RESET_PC in the cycle after rst_i deasserts.
  - A reset mid-stall or mid-flush overrides everything.
- pc_F_o = pc + 32'd4, 32-bit wrap: 0xFFFF_FFFC -> 0x0000_0000.
- pred_taken = (pred_pc_i != pc_F_o).
- Next-PC priority, highest first:
  1. rst_i -> RESET_PC.
  2. hit_miss_i -> pc_X_i + 4.
  3. pc_sel_i -> {redirect_pc_i[31:2], 2'b00}.
  4. stall_i -> hold pc.
  5. Otherwise -> {pred_pc_i[31:2], 2'b00}.
- hit_miss_i and pc_sel_i asserted together: hit_miss_i wins; this counts as a single correction event.
- Flush, when hit_miss_i or pc_sel_i:
  - flush_o=1 in the same cycle.
  - Next edge: valid_D_o<=0, inst_D_o<=NOP_INST, pred_taken_D_o<=0.
  - Flush overrides stall_i; the PC also updates despite the stall.
- misalign_o <= pc_sel_i & redirect_pc_i[1] & ~hit_miss_i.
  - One cycle only.
  - The target is still force-aligned.
- Stall without flush: pc and all IF/ID fields hold their values. The imem address stays stable, so the fetched word is re-read.
- Normal advance:
  - valid_D_o<=1, pc_D_o<=pc, inst_D_o<=imem_rdata_i, pred_taken_D_o<=pred_taken.
- Latency:
  - An instruction fetched in cycle N appears on the IF/ID outputs in cycle N+1.
  - A redirect in cycle N puts the target on imem_addr_o in cycle N+1. Two wrong-path slots are killed (IF/ID and ID/EX via flush_o).
- The BTB is fed only from the current-cycle PC. There is no bypass of BTB writes in the same cycle.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - perf_redirect_o increments by 1 per cycle with (hit_miss_i | pc_sel_i).
  - perf_pred_taken_o increments per non-stalled, non-flushed fetch with pred_taken=1.
  - Both wrap at 2^32 and clear on rst_i.
- Undefined: no counter flops; both outputs are constant 0. The ports always exist.

Decomposition:
- Package fetch_pkg:
  - NOP_INST_C.
  - Opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111.
  - Packed struct if_id_t {pc, inst, pred_taken, valid}.
- Sub-module if_id_reg: holds if_id_t with stall/flush/reset and the priority rst > flush > stall > load.
- PC logic and counters live in fetch_pc_unit.

Test Plan:
- Reset, RESET_PC=0, pred_pc_i=pc_F_o: rst_i 3 cycles then release -> imem_addr_o 0x0, 0x4, 0x8, 0xC on consecutive cycles. valid_D_o=0 in the first cycle after release, then 1 with pc_D_o lagging by one cycle.
- Predicted taken: at pc=0x10, pred_pc_i=0x80 -> next imem_addr_o=0x80. Next cycle pred_taken_D_o=1 and pc_D_o=0x10.
- Mispredict: hit_miss_i=1, pc_X_i=0x40 -> flush_o=1 same cycle. Next cycle imem_addr_o=0x44, valid_D_o=0, inst_D_o=0x00000013.
- Simultaneous events: pc_sel_i=1, redirect_pc_i=0x202, stall_i=1 -> imem_addr_o=0x200 next cycle, misalign_o=1 for one cycle, IF/ID flushed. Repeating with hit_miss_i=1 and pc_X_i=0x100 -> 0x104, misalign_o=0.
- Stall hold: stall_i=1 for 4 cycles at pc=0x20 -> imem_addr_o and all IF/ID outputs unchanged; advance resumes on release. PC wrap: pc=0xFFFF_FFFC -> pc_F_o=0x0.
- FETCH_PERF_CNT_EN defined: 3 redirects and 5 taken fetches -> perf_redirect_o=3, perf_pred_taken_o=5; rst_i -> both 0. Undefined -> both always 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants: IF/ID record, default NOP and the
// control-flow opcodes the fetch path recognises.
package fetch_pkg;

   localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_taken;
      logic        valid;
   } if_id_t;

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register; priority reset > flush > stall > load.
// A flush kills the slot but keeps the previous pc field.
module if_id_reg
   import fetch_pkg::*;
#(
   parameter logic [31:0] NOP_INST = NOP_INST_C
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   stall_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t q_q;
   if_id_t q_d;

   always_comb begin
      q_d = q_q;
      if (flush_i) begin
         q_d.valid      = 1'b0;
         q_d.inst       = NOP_INST;
         q_d.pred_taken = 1'b0;
      end else if (!stall_i) begin
         q_d = d_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         q_q <= '{pc: '0, inst: NOP_INST, pred_taken: 1'b0, valid: 1'b0};
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch stage: PC register, next-PC select, BTB fetch-side outputs, IF/ID.
// Optional perf counters are compiled in with FETCH_PERF_CNT_EN.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_IDX_W = 13,
   parameter logic [31:0] NOP_INST = NOP_INST_C
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                stall_i,
   output logic [31:0]         imem_addr_o,
   input  logic [31:0]         imem_rdata_i,
   output logic [31:0]         pc_F_o,
   output logic [PC_IDX_W-1:0] pc_present_o,
   output logic [31:0]         inst_F_o,
   input  logic [31:0]         pred_pc_i,
   input  logic                pc_sel_i,
   input  logic [31:0]         redirect_pc_i,
   input  logic                hit_miss_i,
   input  logic [31:0]         pc_X_i,
   output logic [31:0]         pc_D_o,
   output logic [31:0]         inst_D_o,
   output logic                pred_taken_D_o,
   output logic                valid_D_o,
   output logic                flush_o,
   output logic                misalign_o,
   output logic [31:0]         perf_redirect_o,
   output logic [31:0]         perf_pred_taken_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] pc_plus4;
   logic        pred_taken;
   logic        redirect;
   logic        misalign_q;
   logic        misalign_d;
   logic        unused_redirect_bit0;
   if_id_t      ifid_d;
   if_id_t      ifid_q;

   assign pc_plus4   = pc_q + 32'd4;
   assign pred_taken = (pred_pc_i != pc_plus4);
   assign redirect   = hit_miss_i | pc_sel_i;

   // Bit 0 of the redirect target is dropped by force-alignment.
   assign unused_redirect_bit0 = redirect_pc_i[0];

   always_comb begin
      if (hit_miss_i) begin
         pc_d = pc_X_i + 32'd4;
      end else if (pc_sel_i) begin
         pc_d = {redirect_pc_i[31:2], 2'b00};
      end else if (stall_i) begin
         pc_d = pc_q;
      end else begin
         pc_d = {pred_pc_i[31:2], 2'b00};
      end
   end

   assign misalign_d = pc_sel_i & redirect_pc_i[1] & ~hit_miss_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q       <= RESET_PC;
         misalign_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         misalign_q <= misalign_d;
      end
   end

   assign ifid_d = '{pc: pc_q, inst: imem_rdata_i, pred_taken: pred_taken, valid: 1'b1};

   if_id_reg #(
      .NOP_INST(NOP_INST)
   ) u_if_id_reg (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .stall_i(stall_i),
      .flush_i(redirect),
      .d_i    (ifid_d),
      .q_o    (ifid_q)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_redirect_q;
   logic [31:0] perf_redirect_d;
   logic [31:0] perf_pt_q;
   logic [31:0] perf_pt_d;

   always_comb begin
      perf_redirect_d = redirect ? perf_redirect_q + 32'd1 : perf_redirect_q;
      perf_pt_d       = (!stall_i && !redirect && pred_taken) ? perf_pt_q + 32'd1 : perf_pt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_redirect_q <= '0;
         perf_pt_q       <= '0;
      end else begin
         perf_redirect_q <= perf_redirect_d;
         perf_pt_q       <= perf_pt_d;
      end
   end

   assign perf_redirect_o   = perf_redirect_q;
   assign perf_pred_taken_o = perf_pt_q;
`else
   assign perf_redirect_o   = '0;
   assign perf_pred_taken_o = '0;
`endif

   assign imem_addr_o    = pc_q;
   assign pc_F_o         = pc_plus4;
   assign pc_present_o   = pc_q[PC_IDX_W+1:2];
   assign inst_F_o       = imem_rdata_i;
   assign flush_o        = redirect;
   assign misalign_o     = misalign_q;
   assign pc_D_o         = ifid_q.pc;
   assign inst_D_o       = ifid_q.inst;
   assign pred_taken_D_o = ifid_q.pred_taken;
   assign valid_D_o      = ifid_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, perf-counter sequence and
// randomized traffic against a behavioural fetch model.
module tb_fetch_pc_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_i, stall_i, pc_sel_i, hit_miss_i;
   logic [31:0] imem_addr_o, imem_rdata_i, pc_F_o, inst_F_o;
   logic [12:0] pc_present_o;
   logic [31:0] pred_pc_i, redirect_pc_i, pc_X_i;
   logic [31:0] pc_D_o, inst_D_o, perf_redirect_o, perf_pred_taken_o;
   logic        pred_taken_D_o, valid_D_o, flush_o, misalign_o;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
   endfunction

   assign imem_rdata_i = mem(imem_addr_o);

   fetch_pc_unit #(
      .RESET_PC(32'h0000_0000),
      .PC_IDX_W(13),
      .NOP_INST(NOP)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i),
      .imem_addr_o(imem_addr_o), .imem_rdata_i(imem_rdata_i),
      .pc_F_o(pc_F_o), .pc_present_o(pc_present_o), .inst_F_o(inst_F_o),
      .pred_pc_i(pred_pc_i), .pc_sel_i(pc_sel_i), .redirect_pc_i(redirect_pc_i),
      .hit_miss_i(hit_miss_i), .pc_X_i(pc_X_i),
      .pc_D_o(pc_D_o), .inst_D_o(inst_D_o), .pred_taken_D_o(pred_taken_D_o),
      .valid_D_o(valid_D_o), .flush_o(flush_o), .misalign_o(misalign_o),
      .perf_redirect_o(perf_redirect_o), .perf_pred_taken_o(perf_pred_taken_o)
   );

   int unsigned n_pass = 0;
   int unsigned n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model of the architectural fetch state
   logic [31:0] m_pc, m_inst, m_pcD, m_cr, m_cp;
   logic        m_valid, m_pt, m_mis;
   logic        last_flush;

   // Apply one cycle of inputs at posedge+1, check combinational outputs before
   // the edge, then advance the model and check registered outputs after it.
   task automatic step(input logic r, s, h, p, seq,
                       input logic [31:0] pred, redir, pcx);
      logic [31:0] n_pc, n_inst, n_pcD, n_cr, n_cp, pp;
      logic        n_valid, n_pt, n_mis, fl, taken;
      pp = seq ? m_pc + 32'd4 : pred;
      rst_i = r; stall_i = s; hit_miss_i = h; pc_sel_i = p;
      pred_pc_i = pp; redirect_pc_i = redir; pc_X_i = pcx;
      #3;
      fl = h | p;
      taken = (pp != m_pc + 32'd4);
      last_flush = flush_o;
      chk("imem_addr", imem_addr_o, m_pc);
      chk("pc_F", pc_F_o, m_pc + 32'd4);
      chk("pc_present", 32'(pc_present_o), 32'(m_pc[14:2]));
      chk("inst_F", inst_F_o, mem(m_pc));
      chk("flush", 32'(flush_o), 32'(fl));
      n_pc = m_pc; n_inst = m_inst; n_pcD = m_pcD; n_valid = m_valid;
      n_pt = m_pt; n_cr = m_cr; n_cp = m_cp;
      if (r) begin
         n_pc = 32'h0; n_valid = 1'b0; n_inst = NOP; n_pcD = 32'h0;
         n_pt = 1'b0; n_mis = 1'b0; n_cr = 32'h0; n_cp = 32'h0;
      end else begin
         if (h) n_pc = pcx + 32'd4;
         else if (p) n_pc = redir & 32'hFFFF_FFFC;
         else if (!s) n_pc = pp & 32'hFFFF_FFFC;
         n_mis = p && redir[1] && !h;
         if (fl) begin
            n_valid = 1'b0; n_inst = NOP; n_pt = 1'b0;
         end else if (!s) begin
            n_valid = 1'b1; n_pcD = m_pc; n_inst = mem(m_pc); n_pt = taken;
         end
         if (fl) n_cr = m_cr + 32'd1;
         if (!s && !fl && taken) n_cp = m_cp + 32'd1;
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_inst = n_inst; m_pcD = n_pcD; m_valid = n_valid;
      m_pt = n_pt; m_mis = n_mis; m_cr = n_cr; m_cp = n_cp;
      chk("pc_next", imem_addr_o, m_pc);
      chk("valid_D", 32'(valid_D_o), 32'(m_valid));
      chk("inst_D", inst_D_o, m_inst);
      if (m_valid) chk("pc_D", pc_D_o, m_pcD);
      chk("pred_taken_D", 32'(pred_taken_D_o), 32'(m_pt));
      chk("misalign", 32'(misalign_o), 32'(m_mis));
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirect", perf_redirect_o, m_cr);
      chk("perf_pred_taken", perf_pred_taken_o, m_cp);
`else
      chk("perf_redirect", perf_redirect_o, 32'h0);
      chk("perf_pred_taken", perf_pred_taken_o, 32'h0);
`endif
   endtask

   typedef struct {
      logic        r, s, h, p, seq;
      logic [31:0] pred, redir, pcx;
      logic        e_flush;
      logic [31:0] e_addr;
      logic        e_valid;
      logic [31:0] e_pcD;
      logic        e_pt, e_mis;
   } vec_t;

   vec_t tbl[25];

   initial begin
      //            r s h p seq pred      redir          pcx        fl addr           v pcD            pt mis
      tbl[0]  = '{1,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h0,         0, 32'h0,         0, 0};
      tbl[1]  = tbl[0];
      tbl[2]  = tbl[0];
      tbl[3]  = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h4,         1, 32'h0,         0, 0};
      tbl[4]  = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h8,         1, 32'h4,         0, 0};
      tbl[5]  = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'hC,         1, 32'h8,         0, 0};
      tbl[6]  = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h10,        1, 32'hC,         0, 0};
      tbl[7]  = '{0,0,0,0,0, 32'h80,   32'h0,         32'h0,     0, 32'h80,        1, 32'h10,        1, 0};
      tbl[8]  = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h84,        1, 32'h80,        0, 0};
      tbl[9]  = '{0,0,1,0,1, 32'h0,    32'h0,         32'h40,    1, 32'h44,        0, 32'h0,         0, 0};
      tbl[10] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h48,        1, 32'h44,        0, 0};
      tbl[11] = '{0,1,0,1,1, 32'h0,    32'h202,       32'h0,     1, 32'h200,       0, 32'h0,         0, 1};
      tbl[12] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h204,       1, 32'h200,       0, 0};
      tbl[13] = '{0,1,1,1,1, 32'h0,    32'h202,       32'h100,   1, 32'h104,       0, 32'h0,         0, 0};
      tbl[14] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h108,       1, 32'h104,       0, 0};
      tbl[15] = '{0,0,0,1,1, 32'h0,    32'h20,        32'h0,     1, 32'h20,        0, 32'h0,         0, 0};
      tbl[16] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h24,        1, 32'h20,        0, 0};
      tbl[17] = '{0,1,0,0,0, 32'h300,  32'h0,         32'h0,     0, 32'h24,        1, 32'h20,        0, 0};
      tbl[18] = tbl[17];
      tbl[19] = tbl[17];
      tbl[20] = tbl[17];
      tbl[21] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h28,        1, 32'h24,        0, 0};
      tbl[22] = '{0,0,0,1,1, 32'h0,    32'hFFFF_FFFC, 32'h0,     1, 32'hFFFF_FFFC, 0, 32'h0,         0, 0};
      tbl[23] = '{0,0,0,0,1, 32'h0,    32'h0,         32'h0,     0, 32'h0,         1, 32'hFFFF_FFFC, 0, 0};
      tbl[24] = '{1,1,0,1,1, 32'h0,    32'h202,       32'h0,     1, 32'h0,         0, 32'h0,         0, 0};

      rst_i = 1'b1; stall_i = 1'b0; hit_miss_i = 1'b0; pc_sel_i = 1'b0;
      pred_pc_i = '0; redirect_pc_i = '0; pc_X_i = '0;
      repeat (2) @(posedge clk);
      #1;
      m_pc = 32'h0; m_inst = NOP; m_pcD = 32'h0; m_valid = 1'b0;
      m_pt = 1'b0; m_mis = 1'b0; m_cr = 32'h0; m_cp = 32'h0;

      for (int i = 0; i < 25; i++) begin
         step(tbl[i].r, tbl[i].s, tbl[i].h, tbl[i].p, tbl[i].seq,
              tbl[i].pred, tbl[i].redir, tbl[i].pcx);
         chk($sformatf("vec%0d_flush", i), 32'(last_flush), 32'(tbl[i].e_flush));
         chk($sformatf("vec%0d_addr", i), imem_addr_o, tbl[i].e_addr);
         chk($sformatf("vec%0d_valid", i), 32'(valid_D_o), 32'(tbl[i].e_valid));
         if (tbl[i].e_valid) begin
            chk($sformatf("vec%0d_pcD", i), pc_D_o, tbl[i].e_pcD);
            chk($sformatf("vec%0d_instD", i), inst_D_o, mem(tbl[i].e_pcD));
         end else begin
            chk($sformatf("vec%0d_instD", i), inst_D_o, NOP);
         end
         chk($sformatf("vec%0d_ptD", i), 32'(pred_taken_D_o), 32'(tbl[i].e_pt));
         chk($sformatf("vec%0d_mis", i), 32'(misalign_o), 32'(tbl[i].e_mis));
      end

      // Perf counters: 5 taken fetches then 3 redirects after a reset
      step(1, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, m_pc + 32'd8, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 32'h400, 0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_redirect_3", perf_redirect_o, 32'd3);
      chk("perf_pred_taken_5", perf_pred_taken_o, 32'd5);
`else
      chk("perf_redirect_off", perf_redirect_o, 32'd0);
      chk("perf_pred_taken_off", perf_pred_taken_o, 32'd0);
`endif
      step(1, 0, 0, 0, 1, 0, 0, 0);
      chk("perf_redirect_rst", perf_redirect_o, 32'd0);
      chk("perf_pred_taken_rst", perf_pred_taken_o, 32'd0);

      for (int i = 0; i < 400; i++) begin
         logic r, s, h, p, seq;
         r   = ($urandom_range(99) < 2);
         s   = ($urandom_range(99) < 20);
         h   = ($urandom_range(99) < 8);
         p   = ($urandom_range(99) < 10);
         seq = ($urandom_range(99) < 60);
         step(r, s, h, p, seq, $urandom, $urandom, $urandom);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
